// File: rtl/lod_pkg.sv
// Shared types and widths for the LOD interpolator datapath.
package lod_pkg;

    // Inverse-interpolator sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULT  = 2'd1,
        ST_DIV   = 2'd2,
        ST_CLAMP = 2'd3
    } lod_state_e;

    // Operand widths: value u0.10, segment edge u0.8, length u10.0.
    localparam int VAL_W  = 10;
    localparam int EDGE_W = 8;
    localparam int LEN_W  = 10;
    // Quotient / dividend width (10-bit magnitude times 10-bit length).
    localparam int QUO_W  = 20;

endpackage

// File: rtl/lod_seq_div.sv
// Restoring divider, one quotient bit per step, MSB first.
// The dividend register shifts out dividend bits and shifts in quotient bits.
module lod_seq_div
    import lod_pkg::*;
#(
    parameter int QW = QUO_W,
    parameter int DW = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [QW-1:0] dividend_i,
    input  logic [DW-1:0] divisor_i,
    output logic [QW-1:0] quot_o,
    output logic          last_o
);
    localparam int CW = $clog2(QW);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [QW-1:0] quot_q, quot_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] div_q;
    logic [DW:0]   trial_d;

    // Trial subtraction for the next quotient bit; the remainder stays below the divisor.
    always_comb begin
        trial_d = {rem_q, quot_q[QW-1]};
        if (trial_d >= {1'b0, div_q}) begin
            rem_d  = DW'(trial_d - {1'b0, div_q});
            quot_d = {quot_q[QW-2:0], 1'b1};
        end else begin
            rem_d  = trial_d[DW-1:0];
            quot_d = {quot_q[QW-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
    end

    // Iteration counter: cleared on load, advanced on every step.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (step_i) begin
            cnt_q <= cnt_d;
        end
    end

    // Dividend/quotient, partial remainder and divisor registers.
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            quot_q <= dividend_i;
            rem_q  <= '0;
            div_q  <= divisor_i;
        end else if (step_i) begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
        end
    end

    assign quot_o = quot_q;
    assign last_o = (cnt_q == CW'(QW - 1));

endmodule

// File: rtl/lod_xy_inv_interp.sv
// Inverse LOD interpolation: x = floor((V - 4L) * N / (4(R - L))), clamped to [0, N].
// Fixed 23-cycle START-to-DONE latency with a sequential divider.
module lod_xy_inv_interp
    import lod_pkg::*;
#(
    parameter int QW = QUO_W,
    parameter int OW = LEN_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [VAL_W-1:0]  VAL_IN,
    input  logic [EDGE_W-1:0] LEFT_VALUE,
    input  logic [EDGE_W-1:0] RIGHT_VALUE,
    input  logic [LEN_W-1:0]  NODE_LEN,
    output logic              BUSY,
    output logic              DONE,
    output logic [OW-1:0]     CURRENT_OUT,
    output logic              DIV0
);
    lod_state_e        state_q;
    logic              busy_q, done_q, div0_out_q;
    logic [OW-1:0]     out_q;
    logic              neg_q, zden_q;
    logic [VAL_W-1:0]  val_q;
    logic [EDGE_W-1:0] left_q, right_q;
    logic [LEN_W-1:0]  len_q;

    logic signed [VAL_W+1:0] num_raw_d, num_n_d;
    logic signed [VAL_W-1:0] den_raw_d, den_n_d;
    logic [VAL_W+1:0]        mag_d;
    logic [QW-1:0]           prod_d;
    logic [9:0]              den4_d;
    logic                    neg_d, zden_d;
    logic [QW-1:0]           quot;
    logic                    div_last;
    logic                    accept;

    // Priority clamp: zero slope, then negative distance, then past the segment end.
    function automatic logic [OW-1:0] clamp_result(input logic zden, input logic neg,
                                                   input logic [QW-1:0] q,
                                                   input logic [OW-1:0] len);
        if (zden || neg) begin
            return '0;
        end else if (q > QW'(len)) begin
            return len;
        end else begin
            return q[OW-1:0];
        end
    endfunction

    assign accept = (state_q == ST_IDLE) && START;

    // Sign normalisation so the divisor is non-negative, then |NUM| * NODE_LEN.
    always_comb begin
        num_raw_d = $signed({2'b00, val_q}) - $signed({2'b00, left_q, 2'b00});
        den_raw_d = $signed({2'b00, right_q}) - $signed({2'b00, left_q});
        num_n_d   = den_raw_d[VAL_W-1] ? -num_raw_d : num_raw_d;
        den_n_d   = den_raw_d[VAL_W-1] ? -den_raw_d : den_raw_d;
        neg_d     = num_n_d[VAL_W+1];
        mag_d     = neg_d ? (VAL_W+2)'(-num_n_d) : (VAL_W+2)'(num_n_d);
        prod_d    = QW'(mag_d) * QW'(len_q);
        den4_d    = {den_n_d[7:0], 2'b00};
        zden_d    = (den_n_d == '0);
    end

    // Operand capture at request acceptance; later input changes are ignored.
    always_ff @(posedge CLK) begin
        if (!RST && accept) begin
            val_q   <= VAL_IN;
            left_q  <= LEFT_VALUE;
            right_q <= RIGHT_VALUE;
            len_q   <= NODE_LEN;
        end
    end

    // Request sequencing and registered handshake / result outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            out_q      <= '0;
            div0_out_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        state_q <= ST_MULT;
                        busy_q  <= 1'b1;
                    end
                end
                ST_MULT: begin
                    neg_q   <= neg_d;
                    zden_q  <= zden_d;
                    state_q <= ST_DIV;
                end
                ST_DIV: begin
                    if (div_last) begin
                        state_q <= ST_CLAMP;
                    end
                end
                ST_CLAMP: begin
                    out_q      <= clamp_result(zden_q, neg_q, quot, OW'(len_q));
                    div0_out_q <= zden_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    lod_seq_div #(
        .QW(QW),
        .DW(10)
    ) u_div (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (state_q == ST_MULT),
        .step_i     (state_q == ST_DIV),
        .dividend_i (prod_d),
        .divisor_i  (den4_d),
        .quot_o     (quot),
        .last_o     (div_last)
    );

    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign CURRENT_OUT = out_q;
    assign DIV0        = div0_out_q;

endmodule
